// File: rtl/wddl_pkg.sv
// Shared dual-rail code constants and rail helpers for the WDDL cell library.
// Bit pairs are written as {p, n}.
package wddl_pkg;

    localparam logic [1:0] DR_ONE    = 2'b10;
    localparam logic [1:0] DR_ZERO   = 2'b01;
    localparam logic [1:0] DR_SPACER = 2'b00;
    localparam logic [1:0] DR_BAD    = 2'b11;

    // A pair is invalid only when both rails are high; spacer is a legal code.
    function automatic logic dr_is_bad(input logic p, input logic n);
        return ({p, n} == DR_BAD);
    endfunction

    function automatic logic dr_is_valid(input logic p, input logic n);
        return ({p, n} == DR_ONE) || ({p, n} == DR_ZERO);
    endfunction

endpackage

// File: rtl/wddl_and_or_bit.sv
// Single-bit WDDL XOR core built only from AND/OR terms, so an all-zero
// precharge wave propagates straight through as a spacer.
module wddl_and_or_bit (
    input  logic a_p,
    input  logic a_n,
    input  logic b_p,
    input  logic b_n,
    output logic y_p,
    output logic y_n
);

    // The product terms are kept as named cells so synthesis cannot fold
    // the two rails back into a single-rail XOR with an inverter.
    (* keep = "true", dont_touch = "true" *) logic t_pn;
    (* keep = "true", dont_touch = "true" *) logic t_np;
    (* keep = "true", dont_touch = "true" *) logic t_pp;
    (* keep = "true", dont_touch = "true" *) logic t_nn;

    assign t_pn = a_p & b_n;
    assign t_np = a_n & b_p;
    assign t_pp = a_p & b_p;
    assign t_nn = a_n & b_n;

    assign y_p = t_pn | t_np;
    assign y_n = t_pp | t_nn;

endmodule

// File: rtl/wddl_xor2_cell.sv
// Parameterised WDDL dual-rail XOR with an optional clocked code checker
// that is used for test and fault observation only.
module wddl_xor2_cell
    import wddl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0_p_in,
    input  logic [WIDTH-1:0] d0_n_in,
    input  logic [WIDTH-1:0] d1_p_in,
    input  logic [WIDTH-1:0] d1_n_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] d_p_out,
    output logic [WIDTH-1:0] d_n_out,
    output logic [WIDTH-1:0] err_vec,
    output logic             err_sticky
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wddl_and_or_bit u_core (
            .a_p (d0_p_in[i]),
            .a_n (d0_n_in[i]),
            .b_p (d1_p_in[i]),
            .b_n (d1_n_in[i]),
            .y_p (d_p_out[i]),
            .y_n (d_n_out[i])
        );
    end

    if (CHECK_EN) begin : g_check
        logic [WIDTH-1:0] bad;

        always_comb begin
            bad = '0;
            for (int i = 0; i < WIDTH; i++) begin
                bad[i] = dr_is_bad(d0_p_in[i], d0_n_in[i])
                       | dr_is_bad(d1_p_in[i], d1_n_in[i])
                       | dr_is_bad(d_p_out[i], d_n_out[i]);
            end
        end

        // A clear in the same cycle as a bad code wins for the sticky flag only.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_vec    <= '0;
                err_sticky <= 1'b0;
            end else begin
                err_vec    <= bad;
                err_sticky <= err_clr ? 1'b0 : (err_sticky | (|bad));
            end
        end
    end else begin : g_no_check
        assign err_vec    = '0;
        assign err_sticky = 1'b0;
    end

endmodule

// File: tb/tb_wddl_xor2_cell.sv
// Directed and random bench for wddl_xor2_cell with immediate-assertion checks.
module tb_wddl_xor2_cell;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] d0_p_in;
    logic [WIDTH-1:0] d0_n_in;
    logic [WIDTH-1:0] d1_p_in;
    logic [WIDTH-1:0] d1_n_in;
    logic             err_clr;
    logic [WIDTH-1:0] d_p_out;
    logic [WIDTH-1:0] d_n_out;
    logic [WIDTH-1:0] err_vec;
    logic             err_sticky;

    int total_count = 0;
    int bad_count   = 0;

    wddl_xor2_cell #(.WIDTH(WIDTH), .CHECK_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d0_p_in    (d0_p_in),
        .d0_n_in    (d0_n_in),
        .d1_p_in    (d1_p_in),
        .d1_n_in    (d1_n_in),
        .err_clr    (err_clr),
        .d_p_out    (d_p_out),
        .d_n_out    (d_n_out),
        .err_vec    (err_vec),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [WIDTH-1:0] observed,
                                input logic [WIDTH-1:0] expected);
        total_count++;
        assert (observed === expected)
        else begin
            bad_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive new operands just after a falling edge, away from the sampling edge.
    task automatic apply_stimulus(input logic [WIDTH-1:0] a_p, input logic [WIDTH-1:0] a_n,
                                  input logic [WIDTH-1:0] b_p, input logic [WIDTH-1:0] b_n);
        @(negedge clk);
        d0_p_in = a_p;
        d0_n_in = a_n;
        d1_p_in = b_p;
        d1_n_in = b_n;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] r_a_p, r_a_n, r_b_p, r_b_n, exp_p, exp_n;
    int sel_a, sel_b;
    logic x;

    initial begin
        rst_n   = 1'b0;
        err_clr = 1'b0;
        d0_p_in = '0;
        d0_n_in = '0;
        d1_p_in = '0;
        d1_n_in = '0;
        #12;
        check_output("reset_err_vec", err_vec, 8'h00);
        check_output("reset_sticky", {7'd0, err_sticky}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(8'hA5, 8'h5A, 8'h3C, 8'hC3);
        check_output("valid_p", d_p_out, 8'h99);
        check_output("valid_n", d_n_out, 8'h66);
        after_edge();
        check_output("valid_err_vec", err_vec, 8'h00);

        apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00);
        check_output("precharge_p", d_p_out, 8'h00);
        check_output("precharge_n", d_n_out, 8'h00);
        after_edge();
        check_output("precharge_err_vec", err_vec, 8'h00);

        apply_stimulus(8'hFF, 8'h00, 8'h0F, 8'hF0);
        check_output("evaluate_p", d_p_out, 8'hF0);
        check_output("evaluate_n", d_n_out, 8'h0F);

        apply_stimulus(8'hA4, 8'h5A, 8'h3C, 8'hC3);
        check_output("mixed_p", d_p_out, 8'h98);
        check_output("mixed_n", d_n_out, 8'h66);
        after_edge();
        check_output("mixed_err_vec", err_vec, 8'h00);
        check_output("mixed_sticky", {7'd0, err_sticky}, 8'h00);

        apply_stimulus(8'h01, 8'h01, 8'h3C, 8'hC3);
        check_output("invalid_p", d_p_out, 8'h01);
        check_output("invalid_n", d_n_out, 8'h01);
        after_edge();
        check_output("invalid_err_vec", err_vec, 8'h01);
        check_output("invalid_sticky", {7'd0, err_sticky}, 8'h01);

        apply_stimulus(8'hA5, 8'h5A, 8'h3C, 8'hC3);
        after_edge();
        check_output("recover_err_vec", err_vec, 8'h00);
        check_output("recover_sticky", {7'd0, err_sticky}, 8'h01);

        @(negedge clk);
        err_clr = 1'b1;
        after_edge();
        check_output("clear_sticky", {7'd0, err_sticky}, 8'h00);

        apply_stimulus(8'h01, 8'h01, 8'h3C, 8'hC3);
        after_edge();
        check_output("clr_and_bad_err_vec", err_vec, 8'h01);
        check_output("clr_and_bad_sticky", {7'd0, err_sticky}, 8'h00);

        @(negedge clk);
        err_clr = 1'b0;
        after_edge();
        check_output("bad_again_sticky", {7'd0, err_sticky}, 8'h01);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("async_rst_err_vec", err_vec, 8'h00);
        check_output("async_rst_sticky", {7'd0, err_sticky}, 8'h00);
        check_output("async_rst_p", d_p_out, 8'h01);
        check_output("async_rst_n", d_n_out, 8'h01);
        after_edge();
        check_output("rst_held_err_vec", err_vec, 8'h00);
        check_output("rst_held_sticky", {7'd0, err_sticky}, 8'h00);

        apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;

        // Each bit independently drawn as spacer, zero or one per operand.
        for (int v = 0; v < 1000; v++) begin
            for (int i = 0; i < WIDTH; i++) begin
                sel_a = $urandom_range(0, 2);
                sel_b = $urandom_range(0, 2);
                r_a_p[i] = (sel_a == 2);
                r_a_n[i] = (sel_a == 1);
                r_b_p[i] = (sel_b == 2);
                r_b_n[i] = (sel_b == 1);
                if (sel_a == 0 || sel_b == 0) begin
                    exp_p[i] = 1'b0;
                    exp_n[i] = 1'b0;
                end else begin
                    x = (sel_a == 2) ^ (sel_b == 2);
                    exp_p[i] = x;
                    exp_n[i] = ~x;
                end
            end
            apply_stimulus(r_a_p, r_a_n, r_b_p, r_b_n);
            check_output("random_p", d_p_out, exp_p);
            check_output("random_n", d_n_out, exp_n);
        end
        after_edge();
        check_output("random_err_vec", err_vec, 8'h00);
        check_output("random_sticky", {7'd0, err_sticky}, 8'h00);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
